// File: rtl/sobel_row_edge_detector.sv
// rtl/sobel_row_edge_detector.sv - row-parallel Sobel edge detector with a 3-row grayscale window
// Takes one RGB row per accepted transfer and emits one row of saturated |Gx|+|Gy| magnitudes.

module sobel_row_edge_detector #(
  parameter int ROW_PIX  = 256,
  parameter int NUM_ROWS = 256,
  parameter int WIDTH    = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [ROW_PIX*WIDTH*3-1:0]   row_in,
  input  logic                         row_in_valid,
  output logic                         row_in_ready,
  output logic [ROW_PIX*WIDTH-1:0]     row_out,
  output logic                         row_out_valid,
  output logic                         frame_done
);

  localparam int CW = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1;
  localparam int PW = WIDTH + 2;
  localparam int GW = WIDTH + 3;
  localparam int MW = WIDTH + 4;
  localparam int RW = ROW_PIX * WIDTH;
  localparam logic [CW-1:0] LAST_ROW = CW'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   top, mid;
  logic [RW-1:0]   y_row;
  logic [RW-1:0]   win_t, win_m, win_b;
  logic [RW-1:0]   edge_row;
  logic            accept, emit, flush;

  function automatic logic [WIDTH-1:0] sobel_px(
    input logic [WIDTH-1:0] tl, tc, tr,
    input logic [WIDTH-1:0] ml, mr,
    input logic [WIDTH-1:0] bl, bc, br
  );
    logic [PW-1:0]        xr, xl, yb, yt;
    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        ax, ay;
    logic [MW-1:0]        mag;
    xr  = PW'(tr) + PW'({mr, 1'b0}) + PW'(br);
    xl  = PW'(tl) + PW'({ml, 1'b0}) + PW'(bl);
    yb  = PW'(bl) + PW'({bc, 1'b0}) + PW'(br);
    yt  = PW'(tl) + PW'({tc, 1'b0}) + PW'(tr);
    gx  = $signed({1'b0, xr}) - $signed({1'b0, xl});
    gy  = $signed({1'b0, yb}) - $signed({1'b0, yt});
    ax  = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay  = gy[GW-1] ? GW'(-gy) : GW'(gy);
    mag = MW'(ax) + MW'(ay);
    return (mag > MW'((1 << WIDTH) - 1)) ? {WIDTH{1'b1}} : mag[WIDTH-1:0];
  endfunction

  // Grayscale conversion of the incoming row, used only at acceptance.
  for (genvar i = 0; i < ROW_PIX; i++) begin : g_gray
    logic [PW-1:0] sum;
    assign sum = PW'(row_in[3*WIDTH*i + 2*WIDTH +: WIDTH])
               + PW'({row_in[3*WIDTH*i + WIDTH +: WIDTH], 1'b0})
               + PW'(row_in[3*WIDTH*i +: WIDTH]);
    assign y_row[WIDTH*i +: WIDTH] = WIDTH'(sum >> 2);
  end

  // Column borders replicate the edge pixel.
  for (genvar c = 0; c < ROW_PIX; c++) begin : g_sobel
    localparam int CL = (c == 0) ? 0 : c - 1;
    localparam int CR = (c == ROW_PIX - 1) ? ROW_PIX - 1 : c + 1;
    assign edge_row[WIDTH*c +: WIDTH] = sobel_px(
      win_t[WIDTH*CL +: WIDTH], win_t[WIDTH*c +: WIDTH], win_t[WIDTH*CR +: WIDTH],
      win_m[WIDTH*CL +: WIDTH], win_m[WIDTH*CR +: WIDTH],
      win_b[WIDTH*CL +: WIDTH], win_b[WIDTH*c +: WIDTH], win_b[WIDTH*CR +: WIDTH]);
  end

  assign row_in_ready = (state != FLUSH);
  assign accept       = row_in_valid && row_in_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Window rows: PRIME replicates row 0 upward, FLUSH replicates the last row downward.
  always_comb begin
    next_state = state;
    emit       = 1'b0;
    flush      = 1'b0;
    win_t      = top;
    win_m      = mid;
    win_b      = y_row;
    case (state)
      IDLE: begin
        if (accept) next_state = PRIME;
      end
      PRIME: begin
        win_t = mid;
        if (accept) begin
          emit       = 1'b1;
          next_state = (NUM_ROWS == 2) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          emit = 1'b1;
          if (cnt == LAST_ROW) next_state = FLUSH;
        end
      end
      FLUSH: begin
        win_b      = mid;
        emit       = 1'b1;
        flush      = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt           <= '0;
      top           <= '0;
      mid           <= '0;
      row_out       <= '0;
      row_out_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      row_out_valid <= emit;
      frame_done    <= flush;
      if (emit) row_out <= edge_row;
      if (accept) begin
        if (state == IDLE) begin
          mid <= y_row;
          cnt <= CW'(1);
        end else begin
          top <= mid;
          mid <= y_row;
          cnt <= (cnt == LAST_ROW) ? cnt : cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_row_edge_detector.sv
// tb/tb_sobel_row_edge_detector.sv - directed self-checking bench for sobel_row_edge_detector
// Four-row, eight-pixel frames with hand-computed edge rows.

module tb_sobel_row_edge_detector;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [191:0] row_in = '0;
  logic         row_in_valid = 1'b0;
  logic         row_in_ready;
  logic [63:0]  row_out;
  logic         row_out_valid;
  logic         frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] got[$];
  logic [3:0]  fd_bits;
  int          rdy_low;
  bit          mon_en = 1'b0;

  sobel_row_edge_detector #(.ROW_PIX(8), .NUM_ROWS(4), .WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .row_in       (row_in),
    .row_in_valid (row_in_valid),
    .row_in_ready (row_in_ready),
    .row_out      (row_out),
    .row_out_valid(row_out_valid),
    .frame_done   (frame_done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (!row_in_ready) rdy_low++;
      if (row_out_valid) begin
        if (got.size() < 4) fd_bits[got.size()] = frame_done;
        got.push_back(row_out);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] gray_row(input logic [63:0] g);
    logic [191:0] r;
    for (int i = 0; i < 8; i++) r[24*i +: 24] = {g[8*i +: 8], g[8*i +: 8], g[8*i +: 8]};
    return r;
  endfunction

  task automatic send_row(input logic [191:0] r, input int gap);
    int n;
    @(negedge CLK);
    row_in       = r;
    row_in_valid = 1'b1;
    n = 0;
    while (!row_in_ready && n < 10) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 10) check("accept_timeout", 64'd0, 64'd1);
    @(posedge CLK);
    if (gap > 0) begin
      @(negedge CLK);
      row_in_valid = 1'b0;
      repeat (gap - 1) @(negedge CLK);
    end
  endtask

  task automatic run_frame(input string tag, input logic [767:0] f, input int gap,
                           input logic [255:0] exp);
    got.delete();
    fd_bits = '0;
    rdy_low = 0;
    mon_en  = 1'b1;
    for (int k = 0; k < 4; k++) send_row(f[192*k +: 192], gap);
    @(negedge CLK);
    row_in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    mon_en = 1'b0;
    check({tag, "_pulses"}, 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      check($sformatf("%s_row%0d", tag, i), got[i], exp[64*i +: 64]);
    check({tag, "_frame_done"}, 64'(fd_bits), 64'h8);
    check({tag, "_ready_low"}, 64'(rdy_low), 64'd1);
  endtask

  logic [191:0] z_row, ff_row, r_pix;
  logic [767:0] f3;

  initial begin
    z_row  = gray_row(64'h0);
    ff_row = gray_row(64'hFFFF_FFFF_FFFF_FFFF);
    r_pix  = '0;
    r_pix[48 +: 24] = 24'h04080C;
    f3 = {ff_row, ff_row, z_row, z_row};

    repeat (2) @(negedge CLK);
    check("rst_row_out", row_out, 64'h0);
    check("rst_valid", 64'(row_out_valid), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_ready", 64'(row_in_ready), 64'd1);
    RST = 1'b1;

    run_frame("uniform", {4{gray_row({8{8'd90}})}}, 0, 256'h0);
    run_frame("vstep", {4{gray_row(64'hFFFF_FFFF_0000_0000)}}, 0,
              {4{64'h0000_00FF_FF00_0000}});
    run_frame("hstep", f3, 0,
              {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    run_frame("gray", {z_row, z_row, r_pix, z_row}, 0,
              {64'h0, 64'h0000_0000_1010_1000, 64'h0000_0000_1000_1000, 64'h0000_0000_1010_1000});
    run_frame("vstep_gap", {4{gray_row(64'hFFFF_FFFF_0000_0000)}}, 3,
              {4{64'h0000_00FF_FF00_0000}});

    for (int k = 0; k < 3; k++) send_row(f3[192*k +: 192], 0);
    @(negedge CLK);
    row_in_valid = 1'b0;
    check("pre_reset_row_out", row_out, 64'hFFFF_FFFF_FFFF_FFFF);
    #2;
    RST = 1'b0;
    #1;
    check("mid_rst_row_out", row_out, 64'h0);
    check("mid_rst_valid", 64'(row_out_valid), 64'd0);
    check("mid_rst_frame_done", 64'(frame_done), 64'd0);
    check("mid_rst_ready", 64'(row_in_ready), 64'd1);
    @(negedge CLK);
    RST = 1'b1;

    run_frame("after_rst", f3, 0,
              {64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
